adder_pipe: RTL and testbench
=============================

Name: adder_pipe

Overview:
Parametrised, pipelined two's-complement adder/subtractor for the datapath; successor to the fixed 32-bit ripple adder.
- Operand width split into STAGES equal slices.
- One slice added per stage; carry registered between stages.
- Valid/ready handshake, one result per cycle, back-pressure stall.
- Sits between the register-read stage and the ALU result mux.

Parameters:
WIDTH, 32, operand and result width in bits; must be divisible by STAGES.
STAGES, 4, pipeline depth and number of WIDTH/STAGES-bit slices; 1..WIDTH.

Ports:
clk_in  input  1  clock; all state on rising edge
rst_n_in  input  1  asynchronous active-low reset
in_valid_in  input  1  operand beat valid
in_ready_out  output  1  block accepts a beat this cycle
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
carry_in  input  1  carry into bit 0 (add mode only)
sub_in  input  1  1 = compute a_in - b_in
out_valid_out  output  1  result valid
out_ready_in  input  1  downstream accepts result
sum_out  output  WIDTH  result
carry_out  output  1  carry out of MSB (1 = no borrow in sub mode)
overflow_out  output  1  signed overflow flag
zero_out  output  1  sum_out == 0 flag

Behaviour:
- Reset (async assert, sync deassert by the system) forces every output to 0 and clears all stage valid bits and data registers. A reset mid-operation discards in-flight beats.
- Operand transform at input:
  - add: B' = b_in, c0 = carry_in.
  - sub: B' = ~b_in, c0 = 1; carry_in is ignored.
- Stage k (0..STAGES-1):
  - Adds slice k of A and B' with the incoming carry.
  - Registers that sum slice, the carry, the already-computed lower slices, and the not-yet-added upper operand slices (input skew / output deskew).
- Latency: a beat accepted at edge N appears on out_valid_out after edge N+STAGES-1, i.e. STAGES register stages. Throughput 1 beat/cycle.
- Handshake:
  - stall = out_valid_out & ~out_ready_in.
  - in_ready_out = ~stall.
  - On stall all stage registers hold and nothing advances.
  - Otherwise every stage shifts by one and stage 0 loads (in_valid_in & in_ready_out).
  - Bubbles advance as invalid entries.
  - out_valid_out/sum_out must not change while stalled.
- Outputs are taken directly from the last stage registers; no combinational path from a_in/b_in to outputs.
- Width rules:
  - Result is modulo 2^WIDTH.
  - carry_out is the carry out of bit WIDTH-1.
  - Overflow = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]); the MSBs are carried along the pipe.
- Simultaneous accept and output in the same cycle is required for full throughput.
- STAGES=1 degenerates to one registered adder, latency 1.
- Elaboration error if WIDTH % STAGES != 0.

Optional Feature:
ADDER_PIPE_FLAGS_EN
- Defined: overflow_out and zero_out are computed and registered in the last stage, aligned with sum_out. zero_out uses the final sum slice plus accumulated lower-slice zero bits.
- Undefined: both ports are tied to 0 and their logic/registers are omitted. sum_out, carry_out and the handshake are unchanged.

Decomposition:
- Package adder_pkg holds:
  - localparam defaults ADDER_WIDTH_DEF=32 and ADDER_STAGES_DEF=4.
  - Function slice_w(width, stages).
  - Typedef adder_op_e {ADD, SUB}.
- One sub-module, adder_pipe_stage: one slice add plus its pipeline registers, hold-on-stall enable and valid bit. It is instantiated STAGES times via a generate loop.

Test Plan:
- Reset, defaults, idle: rst_n_in low → all outputs 0; after release, in_ready_out=1, out_valid_out=0.
- Add: a=0xFFFF_FFFF, b=0x0000_0001, carry_in=0 → after 4 cycles sum=0, carry=1, zero=1, overflow=0.
- Sub: a=0x8000_0000, b=1 → sum=0x7FFF_FFFF, carry=1, overflow=1. Also a=5, b=7 → sum=0xFFFF_FFFE, carry=0.
- Back-to-back throughput: 100 random beats with out_ready_in=1 → one result/cycle, matching reference model, in order.
- Stall: hold out_ready_in=0 for 5 cycles with the pipe full → in_ready_out=0 and sum_out stable. Release → no beat lost or duplicated.
- Reset mid-stream: assert rst_n_in with 3 beats in flight → outputs 0 immediately. After release, the first new beat (a=2, b=3) yields 5 with no stale results.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: default geometry,
// slice-width helper and the operation encoding.
package adder_pkg;

    localparam int ADDER_WIDTH_DEF  = 32;
    localparam int ADDER_STAGES_DEF = 4;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } adder_op_e;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline stage: adds slice IDX of the skewed operands and registers the
// partially-built result, the carry and (with ADDER_PIPE_FLAGS_EN) the flag state.
module adder_pipe_stage
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH_DEF,
    parameter int STAGES = ADDER_STAGES_DEF,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_res,
    input  logic [WIDTH-1:0] prev_b,
    input  logic             prev_carry,
`ifdef ADDER_PIPE_FLAGS_EN
    input  logic             prev_zero,
    input  logic             prev_a_msb,
    input  logic             prev_b_msb,
    output logic             zero,
    output logic             overflow,
    output logic             a_msb,
    output logic             b_msb,
`endif
    output logic             valid,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] b,
    output logic             carry
);

    localparam int SW = slice_w(WIDTH, STAGES);
    localparam int LO = IDX * SW;

    logic [SW:0]      slice_sum;
    logic [WIDTH-1:0] res_next;

    // Bits below LO already hold sum slices; bits above still hold operand A.
    always_comb begin
        slice_sum          = {1'b0, prev_res[LO +: SW]} + {1'b0, prev_b[LO +: SW]}
                           + (SW+1)'(prev_carry);
        res_next           = prev_res;
        res_next[LO +: SW] = slice_sum[SW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            res   <= '0;
            b     <= '0;
            carry <= 1'b0;
        end else if (advance) begin
            valid <= prev_valid;
            res   <= res_next;
            b     <= prev_b;
            carry <= slice_sum[SW];
        end
    end

`ifdef ADDER_PIPE_FLAGS_EN
    // Overflow only becomes meaningful once the MSB slice is added (last stage).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero     <= 1'b0;
            overflow <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
        end else if (advance) begin
            zero     <= prev_zero & (slice_sum[SW-1:0] == '0);
            overflow <= (prev_a_msb == prev_b_msb) & (res_next[WIDTH-1] != prev_a_msb);
            a_msb    <= prev_a_msb;
            b_msb    <= prev_b_msb;
        end
    end
`endif

endmodule

// File: rtl/adder_pipe.sv
// Pipelined two's-complement adder/subtractor, one WIDTH/STAGES slice per stage.
// Optional flags (overflow_out, zero_out) are built when ADDER_PIPE_FLAGS_EN is defined.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH_DEF,
    parameter int STAGES = ADDER_STAGES_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    input  logic             sub_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out,
    output logic             zero_out
);

    generate
        if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_bad_geometry
            $error("adder_pipe: WIDTH must be divisible by STAGES, 1 <= STAGES <= WIDTH");
        end
    endgenerate

    // Handshake: a beat moves on a rising edge when valid & ready are both high.
    // The whole pipe freezes only when a valid result is refused downstream, so
    // accept and deliver can happen in the same cycle.
    logic      stall;
    adder_op_e op;

    logic             stg_valid [0:STAGES];
    logic [WIDTH-1:0] stg_res   [0:STAGES];
    logic [WIDTH-1:0] stg_b     [0:STAGES];
    logic             stg_carry [0:STAGES];

    assign stall        = out_valid_out & ~out_ready_in;
    assign in_ready_out = rst_n_in & ~stall;
    assign op           = sub_in ? SUB : ADD;

    assign stg_valid[0] = in_valid_in & in_ready_out;
    assign stg_res[0]   = a_in;
    assign stg_b[0]     = (op == SUB) ? ~b_in : b_in;
    assign stg_carry[0] = (op == SUB) ? 1'b1 : carry_in;

`ifdef ADDER_PIPE_FLAGS_EN
    logic stg_zero  [0:STAGES];
    logic stg_ovf   [0:STAGES];
    logic stg_a_msb [0:STAGES];
    logic stg_b_msb [0:STAGES];

    assign stg_zero[0]  = 1'b1;
    assign stg_ovf[0]   = 1'b0;
    assign stg_a_msb[0] = a_in[WIDTH-1];
    assign stg_b_msb[0] = stg_b[0][WIDTH-1];
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (k)
        ) u_stage (
            .clk        (clk_in),
            .rst_n      (rst_n_in),
            .advance    (~stall),
            .prev_valid (stg_valid[k]),
            .prev_res   (stg_res[k]),
            .prev_b     (stg_b[k]),
            .prev_carry (stg_carry[k]),
`ifdef ADDER_PIPE_FLAGS_EN
            .prev_zero  (stg_zero[k]),
            .prev_a_msb (stg_a_msb[k]),
            .prev_b_msb (stg_b_msb[k]),
            .zero       (stg_zero[k+1]),
            .overflow   (stg_ovf[k+1]),
            .a_msb      (stg_a_msb[k+1]),
            .b_msb      (stg_b_msb[k+1]),
`endif
            .valid      (stg_valid[k+1]),
            .res        (stg_res[k+1]),
            .b          (stg_b[k+1]),
            .carry      (stg_carry[k+1])
        );
    end

    assign out_valid_out = stg_valid[STAGES];
    assign sum_out       = stg_res[STAGES];
    assign carry_out     = stg_carry[STAGES];

`ifdef ADDER_PIPE_FLAGS_EN
    assign overflow_out = stg_ovf[STAGES];
    assign zero_out     = stg_zero[STAGES];
`else
    assign overflow_out = 1'b0;
    assign zero_out     = 1'b0;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed corner cases, random traffic with
// back-pressure, stall and mid-stream reset against an arithmetic reference model.
module tb_adder_pipe;

    localparam int W = 32;
    localparam int S = 4;
`ifdef ADDER_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         in_valid_in;
    logic         in_ready_out;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         carry_in;
    logic         sub_in;
    logic         out_valid_out;
    logic         out_ready_in;
    logic [W-1:0] sum_out;
    logic         carry_out;
    logic         overflow_out;
    logic         zero_out;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .in_valid_in   (in_valid_in),
        .in_ready_out  (in_ready_out),
        .a_in          (a_in),
        .b_in          (b_in),
        .carry_in      (carry_in),
        .sub_in        (sub_in),
        .out_valid_out (out_valid_out),
        .out_ready_in  (out_ready_in),
        .sum_out       (sum_out),
        .carry_out     (carry_out),
        .overflow_out  (overflow_out),
        .zero_out      (zero_out)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [2:0]   exp_flag_q[$];   // {carry, overflow, zero}
    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide integer arithmetic, independent of slicing.
    task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ci, input logic sb);
        longint ua, ub, sa, sbv, full, sres;
        logic [W-1:0] sum;
        logic c, ov, z;
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (sb) begin
            full = ua - ub;
            c    = (ua >= ub);
            sres = sa - sbv;
        end else begin
            full = ua + ub + longint'(ci);
            c    = (full >= (64'sd1 <<< W));
            sres = sa + sbv + longint'(ci);
        end
        sum = full[W-1:0];
        ov  = (sres > ((64'sd1 <<< (W-1)) - 1)) || (sres < -(64'sd1 <<< (W-1)));
        z   = (sum == '0);
        exp_q.push_back(sum);
        exp_flag_q.push_back({c, ov & FLAGS, z & FLAGS});
    endtask

    // ---------------- driver ----------------
    // One cycle: drive at negedge, sample #1 later, well away from the rising edge.
    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb, input logic ordy);
        logic [W-1:0] es;
        logic [2:0]   ef;
        @(negedge clk_in);
        in_valid_in  = iv;
        a_in         = a;
        b_in         = b;
        carry_in     = ci;
        sub_in       = sb;
        out_ready_in = ordy;
        #1;
        if (out_valid_out && out_ready_in) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_output", 64'(sum_out), 64'hDEAD_0000_0000);
            end else begin
                es = exp_q.pop_front();
                ef = exp_flag_q.pop_front();
                check_eq("sum", 64'(sum_out), 64'(es));
                check_eq("carry", 64'(carry_out), 64'(ef[2]));
                check_eq("overflow", 64'(overflow_out), 64'(ef[1]));
                check_eq("zero", 64'(zero_out), 64'(ef[0]));
            end
        end
        if (in_valid_in && in_ready_out) model_push(a, b, ci, sb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    // Single beat into an empty pipe; also measures latency.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic sb);
        int k;
        step(1'b1, a, b, ci, sb, 1'b1);
        k = 0;
        do begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            k++;
        end while (!out_valid_out && k < 20);
        check_eq("latency", 64'(k), 64'(S));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid_out) && k < 100) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            k++;
        end
        check_eq("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_sum"}, 64'(sum_out), 64'd0);
        check_eq({tag, "_valid"}, 64'(out_valid_out), 64'd0);
        check_eq({tag, "_carry"}, 64'(carry_out), 64'd0);
        check_eq({tag, "_ovf"}, 64'(overflow_out), 64'd0);
        check_eq({tag, "_zero"}, 64'(zero_out), 64'd0);
        check_eq({tag, "_ready"}, 64'(in_ready_out), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int p0;
        logic [W-1:0] held;

        rst_n_in     = 1'b0;
        in_valid_in  = 1'b0;
        a_in         = '0;
        b_in         = '0;
        carry_in     = 1'b0;
        sub_in       = 1'b0;
        out_ready_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_outputs("reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        check_eq("idle_ready", 64'(in_ready_out), 64'd1);
        check_eq("idle_valid", 64'(out_valid_out), 64'd0);

        // Directed corner cases
        run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        run_one(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        run_one(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_one(32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1);
        run_one(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        drain();

        // Back-to-back throughput
        p0 = n_pop;
        for (int i = 0; i < 100; i++)
            step(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1);
        check_eq("throughput", 64'(n_pop - p0), 64'(100 - S));
        drain();

        // Stall with full pipe
        for (int i = 0; i < S; i++)
            step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        held = sum_out;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0);
            if (i == 0) held = sum_out;
            check_eq("stall_ready", 64'(in_ready_out), 64'd0);
            check_eq("stall_valid", 64'(out_valid_out), 64'd1);
            check_eq("stall_sum", 64'(sum_out), 64'(held));
        end
        drain();

        // Random valid / ready mix
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
        drain();

        // Reset with beats in flight
        for (int i = 0; i < 3; i++)
            step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b1);
        @(negedge clk_in);
        in_valid_in = 1'b0;
        rst_n_in    = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        exp_flag_q.delete();
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        run_one(32'd2, 32'd3, 1'b0, 1'b0);
        idle(S + 2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
